// File: rtl/madgwick_sequencer.sv
// Hardware pacing for the madgwick core: latches the newest IMU sample, launches one
// core update per sample period, captures the quaternion and flags overruns/hangs.
module madgwick_sequencer #(
    parameter int ACC_W       = 16,
    parameter int GYRO_W      = 16,
    parameter int Q_W         = 32,
    parameter int PERIOD_W    = 24,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                imu_valid,
    output logic                imu_ready,
    input  logic [ACC_W-1:0]    imu_a_x,
    input  logic [ACC_W-1:0]    imu_a_y,
    input  logic [ACC_W-1:0]    imu_a_z,
    input  logic [GYRO_W-1:0]   imu_w_x,
    input  logic [GYRO_W-1:0]   imu_w_y,
    input  logic [GYRO_W-1:0]   imu_w_z,
    output logic                core_rst_n,
    output logic                core_valid_in,
    input  logic                core_ready_in,
    output logic [ACC_W-1:0]    core_a_x,
    output logic [ACC_W-1:0]    core_a_y,
    output logic [ACC_W-1:0]    core_a_z,
    output logic [GYRO_W-1:0]   core_w_x,
    output logic [GYRO_W-1:0]   core_w_y,
    output logic [GYRO_W-1:0]   core_w_z,
    input  logic                core_valid_out,
    output logic                core_ready_out,
    input  logic [Q_W-1:0]      core_q_w,
    input  logic [Q_W-1:0]      core_q_x,
    input  logic [Q_W-1:0]      core_q_y,
    input  logic [Q_W-1:0]      core_q_z,
    output logic [Q_W-1:0]      q_w,
    output logic [Q_W-1:0]      q_x,
    output logic [Q_W-1:0]      q_y,
    output logic [Q_W-1:0]      q_z,
    output logic                q_valid,
    output logic                busy,
    output logic [7:0]          overrun_cnt,
    output logic                timeout,
    output logic [1:0]          state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] W_ONE = TW'(1);
    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [PERIOD_W-1:0] tick_cnt;
    logic                run;
    logic                tick;
    logic                enable_q;
    logic                en_rise;
    logic [TW-1:0]       wait_cnt;
    logic                rec_cnt;
    logic                fresh;
    logic                launch;
    logic                capture;
    logic                hang;
    logic [ACC_W-1:0]    smp_a_x, smp_a_y, smp_a_z;
    logic [GYRO_W-1:0]   smp_w_x, smp_w_y, smp_w_z;

    assign run     = enable && (period != '0);
    assign tick    = run && (tick_cnt == period - P_ONE);
    assign en_rise = enable && !enable_q;

    assign imu_ready      = 1'b1;
    assign core_valid_in  = enable && (state == S_LAUNCH);
    assign core_ready_out = enable && (state == S_WAIT);
    assign busy           = (state == S_LAUNCH) || (state == S_WAIT);
    assign state_dbg      = state;

    // Valid/ready: a transfer happens in any cycle where both sides are high at the
    // rising edge; the launch side holds valid and operands until that cycle.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        capture   = 1'b0;
        hang      = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick && fresh) begin
                        launch    = 1'b1;
                        state_nxt = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (core_ready_in) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (core_valid_out) begin
                        capture   = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        hang      = 1'b1;
                        state_nxt = S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    if (rec_cnt) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Counter wraps on reaching period-1, or at once if period shrank below it.
    always_ff @(posedge clk) begin
        if (rst || !run)                     tick_cnt <= '0;
        else if (tick_cnt >= period - P_ONE) tick_cnt <= '0;
        else                                 tick_cnt <= tick_cnt + P_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q    <= 1'b0;
            wait_cnt    <= '0;
            rec_cnt     <= 1'b0;
            core_rst_n  <= 1'b0;
            fresh       <= 1'b0;
            smp_a_x     <= '0;
            smp_a_y     <= '0;
            smp_a_z     <= '0;
            smp_w_x     <= '0;
            smp_w_y     <= '0;
            smp_w_z     <= '0;
            core_a_x    <= '0;
            core_a_y    <= '0;
            core_a_z    <= '0;
            core_w_x    <= '0;
            core_w_y    <= '0;
            core_w_z    <= '0;
            q_w         <= '0;
            q_x         <= '0;
            q_y         <= '0;
            q_z         <= '0;
            q_valid     <= 1'b0;
            overrun_cnt <= '0;
            timeout     <= 1'b0;
        end else begin
            enable_q   <= enable;
            wait_cnt   <= (enable && state == S_WAIT) ? wait_cnt + W_ONE : '0;
            rec_cnt    <= (enable && state == S_RECOVER) ? !rec_cnt : 1'b0;
            core_rst_n <= enable && (state != S_RECOVER);

            // The copy reads the old sample; a same-cycle strobe refills and stays fresh.
            if (launch) begin
                fresh    <= 1'b0;
                core_a_x <= smp_a_x;
                core_a_y <= smp_a_y;
                core_a_z <= smp_a_z;
                core_w_x <= smp_w_x;
                core_w_y <= smp_w_y;
                core_w_z <= smp_w_z;
            end
            if (imu_valid) begin
                fresh   <= 1'b1;
                smp_a_x <= imu_a_x;
                smp_a_y <= imu_a_y;
                smp_a_z <= imu_a_z;
                smp_w_x <= imu_w_x;
                smp_w_y <= imu_w_y;
                smp_w_z <= imu_w_z;
            end

            q_valid <= capture;
            if (capture) begin
                q_w <= core_q_w;
                q_x <= core_q_x;
                q_y <= core_q_y;
                q_z <= core_q_z;
            end

            if (en_rise)
                overrun_cnt <= '0;
            else if (tick && state != S_IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            if (en_rise)   timeout <= 1'b0;
            else if (hang) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_madgwick_sequencer.sv
// Bench for madgwick_sequencer: behavioural core model, expected-quaternion queue
// filled from driven IMU samples, one task per scenario.
module tb_madgwick_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] period = '0;
    logic        imu_valid = 1'b0;
    logic [15:0] imu_a_x = '0, imu_a_y = '0, imu_a_z = '0;
    logic [15:0] imu_w_x = '0, imu_w_y = '0, imu_w_z = '0;
    logic        imu_ready, core_rst_n, core_valid_in, core_ready_in;
    logic [15:0] core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z;
    logic        core_valid_out = 1'b0;
    logic        core_ready_out;
    logic [31:0] core_q_w, core_q_x, core_q_y, core_q_z;
    logic [31:0] q_w, q_x, q_y, q_z;
    logic        q_valid, busy, timeout;
    logic [7:0]  overrun_cnt;
    logic [1:0]  state_dbg;

    madgwick_sequencer #(
        .ACC_W(16), .GYRO_W(16), .Q_W(32), .PERIOD_W(24), .TIMEOUT_CYC(4096)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period),
        .imu_valid(imu_valid), .imu_ready(imu_ready),
        .imu_a_x(imu_a_x), .imu_a_y(imu_a_y), .imu_a_z(imu_a_z),
        .imu_w_x(imu_w_x), .imu_w_y(imu_w_y), .imu_w_z(imu_w_z),
        .core_rst_n(core_rst_n), .core_valid_in(core_valid_in), .core_ready_in(core_ready_in),
        .core_a_x(core_a_x), .core_a_y(core_a_y), .core_a_z(core_a_z),
        .core_w_x(core_w_x), .core_w_y(core_w_y), .core_w_z(core_w_z),
        .core_valid_out(core_valid_out), .core_ready_out(core_ready_out),
        .core_q_w(core_q_w), .core_q_x(core_q_x), .core_q_y(core_q_y), .core_q_z(core_q_z),
        .q_w(q_w), .q_x(q_x), .q_y(q_y), .q_z(q_z), .q_valid(q_valid),
        .busy(busy), .overrun_cnt(overrun_cnt), .timeout(timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- core model ----------------
    int          core_lat = 20;
    bit          core_hang = 1'b0;
    int          stall_cfg = 0;
    int          stall_left = 0;
    int          lat_left = 0;
    logic        m_busy = 1'b0;
    logic [127:0] m_res = '0;

    function automatic logic [127:0] qfun(input logic [15:0] ax, ay, az, wx, wy, wz);
        return {ax, wx, ay, wy, az, wz, ax ^ wz, ay ^ wx};
    endfunction

    assign {core_q_w, core_q_x, core_q_y, core_q_z} = m_res;
    assign core_ready_in = core_rst_n && !m_busy && !core_valid_out && (stall_left == 0);

    always @(posedge clk) begin
        if (!core_rst_n) begin
            m_busy         <= 1'b0;
            core_valid_out <= 1'b0;
            stall_left     <= stall_cfg;
            lat_left       <= 0;
        end else if (core_valid_out) begin
            if (core_ready_out) core_valid_out <= 1'b0;
        end else if (m_busy) begin
            if (lat_left <= 1) begin
                if (!core_hang) begin
                    core_valid_out <= 1'b1;
                    m_busy         <= 1'b0;
                end
            end else begin
                lat_left <= lat_left - 1;
            end
        end else if (core_valid_in) begin
            if (stall_left > 0) begin
                stall_left <= stall_left - 1;
            end else begin
                m_busy     <= 1'b1;
                lat_left   <= core_lat;
                m_res      <= qfun(core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z);
                stall_left <= stall_cfg;
            end
        end else begin
            stall_left <= stall_cfg;
        end
    end

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    logic [127:0] steady_exp = '0;
    logic [127:0] last_exp = '0;
    bit           steady = 1'b0;
    int           qv_count = 0;
    int           last_qv = -1;
    int           chk_period = 0;

    always @(negedge clk) begin
        logic [127:0] got, want;
        if (q_valid === 1'b1) begin
            qv_count++;
            got = {q_w, q_x, q_y, q_z};
            checks++;
            if (steady) begin
                want = steady_exp;
                if (got !== want) $display("FAIL q_steady: got %h want %h", got, want);
                else passes++;
            end else if (exp_q.size() == 0) begin
                $display("FAIL q_unexpected: q_valid with %h, nothing expected", got);
            end else begin
                want = exp_q.pop_front();
                last_exp = want;
                if (got !== want) $display("FAIL q_value: got %h want %h", got, want);
                else passes++;
            end
            if (chk_period != 0 && last_qv >= 0) begin
                checks++;
                if (cyc - last_qv !== chk_period)
                    $display("FAIL q_interval: got %0d want %0d", cyc - last_qv, chk_period);
                else passes++;
            end
            last_qv = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic en);
        @(negedge clk);
        rst = 1'b1;
        enable = en;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_sample(input logic [15:0] ax, ay, az, wx, wy, wz);
        {imu_a_x, imu_a_y, imu_a_z, imu_w_x, imu_w_y, imu_w_z} = {ax, ay, az, wx, wy, wz};
    endtask

    task automatic pulse_random(output logic [127:0] e);
        logic [15:0] v[6];
        for (int i = 0; i < 6; i++) v[i] = 16'($urandom_range(0, 65535));
        set_sample(v[0], v[1], v[2], v[3], v[4], v[5]);
        e = qfun(v[0], v[1], v[2], v[3], v[4], v[5]);
        imu_valid = 1'b1;
        @(negedge clk);
        imu_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({q_w, q_x, q_y, q_z} !== 128'b0) $display("FAIL reset_q: got %h want 0", {q_w, q_x, q_y, q_z});
        else passes++;
        checks++;
        if ({q_valid, busy, timeout, core_valid_in, core_ready_out, core_rst_n} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000",
                     {q_valid, busy, timeout, core_valid_in, core_ready_out, core_rst_n});
        else passes++;
        checks++;
        if (overrun_cnt !== 8'd0 || state_dbg !== 2'd0)
            $display("FAIL reset_cnt: overrun %0d state %0d want 0 0", overrun_cnt, state_dbg);
        else passes++;
        checks++;
        if (imu_ready !== 1'b1) $display("FAIL reset_imu_ready: got %b want 1", imu_ready);
        else passes++;
        checks++;
        if ({core_a_x, core_w_z} !== 32'b0) $display("FAIL reset_ops: got %h want 0", {core_a_x, core_w_z});
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (core_rst_n !== 1'b1) $display("FAIL release_core_rst_n: got %b want 1", core_rst_n);
        else passes++;
    endtask

    task automatic test_periodic;
        logic [127:0] e;
        int q0;
        period = 24'd100;
        core_lat = 20;
        do_reset(1'b1);
        q0 = qv_count;
        last_qv = -1;
        chk_period = 100;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            pulse_random(e);
            exp_q.push_back(e);
            repeat (99) @(negedge clk);
        end
        repeat (60) @(negedge clk);
        chk_period = 0;
        checks++;
        if (qv_count - q0 !== 5) $display("FAIL periodic_count: got %0d want 5", qv_count - q0);
        else passes++;
        checks++;
        if (exp_q.size() !== 0) $display("FAIL periodic_drain: got %0d pending want 0", exp_q.size());
        else passes++;
        checks++;
        if (overrun_cnt !== 8'd0 || timeout !== 1'b0)
            $display("FAIL periodic_flags: overrun %0d timeout %b want 0 0", overrun_cnt, timeout);
        else passes++;
    endtask

    task automatic test_same_cycle;
        logic [15:0] base;
        logic [15:0] dax[16];
        logic [15:0] dwx[16];
        int q0;
        period = 24'd16;
        core_lat = 5;
        do_reset(1'b0);
        repeat (2) @(negedge clk);
        base = 16'($urandom_range(0, 16'h7fff));
        for (int k = 0; k < 16; k++) begin
            dax[k] = base + 16'(k);
            dwx[k] = ~(base + 16'(3 * k));
        end
        exp_q.push_back(qfun(dax[14], 16'h1111, 16'h2222, dwx[14], 16'h3333, 16'h4444));
        exp_q.push_back(qfun(dax[15], 16'h1111, 16'h2222, dwx[15], 16'h3333, 16'h4444));
        q0 = qv_count;
        enable = 1'b1;
        imu_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            set_sample(dax[k], 16'h1111, 16'h2222, dwx[k], 16'h3333, 16'h4444);
            @(negedge clk);
        end
        imu_valid = 1'b0;
        checks++;
        if (core_a_x !== dax[14] || core_w_x !== dwx[14])
            $display("FAIL same_cycle_ops: got %h/%h want %h/%h", core_a_x, core_w_x, dax[14], dwx[14]);
        else passes++;
        repeat (45) @(negedge clk);
        checks++;
        if (qv_count - q0 !== 2) $display("FAIL same_cycle_count: got %0d want 2", qv_count - q0);
        else passes++;
        checks++;
        if (exp_q.size() !== 0) $display("FAIL same_cycle_drain: got %0d pending want 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_ready_stall;
        logic [127:0] e;
        int n;
        period = 24'd20;
        core_lat = 5;
        stall_cfg = 10;
        do_reset(1'b1);
        pulse_random(e);
        exp_q.push_back(e);
        n = 0;
        while (core_valid_in !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (core_valid_in !== 1'b1) $display("FAIL stall_launch_wait: valid_in %b want 1", core_valid_in);
        else passes++;
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (core_valid_in !== 1'b1 || core_ready_in !== 1'b0 ||
                qfun(core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z) !== e)
                $display("FAIL stall_hold_%0d: valid %b ready %b ops %h want 1 0 %h", j,
                         core_valid_in, core_ready_in,
                         qfun(core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z), e);
            else passes++;
            @(negedge clk);
        end
        checks++;
        if (core_valid_in !== 1'b1 || core_ready_in !== 1'b1)
            $display("FAIL stall_handshake: valid %b ready %b want 1 1", core_valid_in, core_ready_in);
        else passes++;
        @(negedge clk);
        checks++;
        if (core_valid_in !== 1'b0 || core_ready_out !== 1'b1)
            $display("FAIL stall_wait: valid_in %b ready_out %b want 0 1", core_valid_in, core_ready_out);
        else passes++;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() !== 0) $display("FAIL stall_drain: got %0d pending want 0", exp_q.size());
        else passes++;
        stall_cfg = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overrun;
        int q0, n;
        period = 24'd100;
        core_lat = 150;
        set_sample(16'h0a0b, 16'h0c0d, 16'h0e0f, 16'h1020, 16'h3040, 16'h5060);
        steady_exp = qfun(16'h0a0b, 16'h0c0d, 16'h0e0f, 16'h1020, 16'h3040, 16'h5060);
        steady = 1'b1;
        imu_valid = 1'b1;
        q0 = qv_count;
        do_reset(1'b1);
        repeat (630) @(negedge clk);
        checks++;
        if (overrun_cnt !== 8'd3) $display("FAIL overrun_per_launch: got %0d want 3", overrun_cnt);
        else passes++;
        checks++;
        if (qv_count - q0 !== 2) $display("FAIL overrun_results: got %0d want 2", qv_count - q0);
        else passes++;
        period = 24'd10;
        repeat (4000) @(negedge clk);
        checks++;
        if (overrun_cnt !== 8'd255) $display("FAIL overrun_saturate: got %0d want 255", overrun_cnt);
        else passes++;
        repeat (400) @(negedge clk);
        checks++;
        if (overrun_cnt !== 8'd255) $display("FAIL overrun_no_wrap: got %0d want 255", overrun_cnt);
        else passes++;
        imu_valid = 1'b0;
        repeat (400) @(negedge clk);
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL overrun_settle: busy %b want 0", busy);
        else passes++;
        repeat (5) @(negedge clk);
        steady = 1'b0;
    endtask

    task automatic test_timeout;
        logic [127:0] e;
        int n, lows;
        period = 24'd100;
        core_lat = 20;
        core_hang = 1'b1;
        pulse_random(e);
        n = 0;
        while (!(core_valid_in === 1'b1 && core_ready_in === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (core_valid_in !== 1'b1 || core_ready_in !== 1'b1)
            $display("FAIL timeout_launch: valid %b ready %b want 1 1", core_valid_in, core_ready_in);
        else passes++;
        repeat (4096) @(negedge clk);
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1)
            $display("FAIL timeout_early: timeout %b busy %b want 0 1", timeout, busy);
        else passes++;
        @(negedge clk);
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0)
            $display("FAIL timeout_set: timeout %b busy %b want 1 0", timeout, busy);
        else passes++;
        lows = 0;
        for (int k = 0; k < 8; k++) begin
            if (core_rst_n === 1'b0) lows++;
            @(negedge clk);
        end
        checks++;
        if (lows !== 2) $display("FAIL timeout_core_rst_len: got %0d want 2", lows);
        else passes++;
        checks++;
        if (overrun_cnt !== 8'd255) $display("FAIL timeout_overrun_kept: got %0d want 255", overrun_cnt);
        else passes++;
        core_hang = 1'b0;
        pulse_random(e);
        exp_q.push_back(e);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() !== 0) $display("FAIL timeout_relaunch: got %0d pending want 0", exp_q.size());
        else passes++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_enable_drop;
        logic [127:0] e;
        int n, q0;
        period = 24'd100;
        core_lat = 50;
        pulse_random(e);
        n = 0;
        while (core_ready_out !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (core_ready_out !== 1'b1) $display("FAIL drop_reach_wait: ready_out %b want 1", core_ready_out);
        else passes++;
        q0 = qv_count;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({core_ready_out, core_rst_n, core_valid_in, busy} !== 4'b0)
            $display("FAIL drop_outputs: got %b want 0000", {core_ready_out, core_rst_n, core_valid_in, busy});
        else passes++;
        repeat (100) @(negedge clk);
        checks++;
        if (qv_count - q0 !== 0) $display("FAIL drop_no_result: got %0d want 0", qv_count - q0);
        else passes++;
        checks++;
        if (overrun_cnt !== 8'd255 || timeout !== 1'b1)
            $display("FAIL drop_kept: overrun %0d timeout %b want 255 1", overrun_cnt, timeout);
        else passes++;
        checks++;
        if ({q_w, q_x, q_y, q_z} !== last_exp) $display("FAIL drop_q_kept: got %h want %h", {q_w, q_x, q_y, q_z}, last_exp);
        else passes++;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (overrun_cnt !== 8'd0 || timeout !== 1'b0)
            $display("FAIL reenable_clear: overrun %0d timeout %b want 0 0", overrun_cnt, timeout);
        else passes++;
    endtask

    task automatic test_reset_mid;
        logic [127:0] e;
        int n, q0;
        core_lat = 50;
        pulse_random(e);
        n = 0;
        while (core_ready_out !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        q0 = qv_count;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, core_rst_n, core_ready_out} !== 3'b0 || {q_w, q_x, q_y, q_z} !== 128'b0)
            $display("FAIL reset_mid: ctrl %b q %h want 000 0", {busy, core_rst_n, core_ready_out}, {q_w, q_x, q_y, q_z});
        else passes++;
        rst = 1'b0;
        repeat (120) @(negedge clk);
        checks++;
        if (qv_count - q0 !== 0) $display("FAIL reset_mid_discard: got %0d want 0", qv_count - q0);
        else passes++;
    endtask

    initial begin
        test_reset;
        test_periodic;
        test_same_cycle;
        test_ready_stall;
        test_overrun;
        test_timeout;
        test_enable_drop;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
        $fatal(1);
    end

endmodule
